// File: rtl/lane_logic_pkg.sv
// Shared lane definitions for the multi-lane d/e logic array: the two
// per-lane boolean functions and the counter saturation helper.
package lane_logic_pkg;

    localparam int LANE_A_WIDTH = 8;

    function automatic logic lane_d(input logic [1:0] a2, input logic [1:0] b2,
                                    input logic [1:0] c2);
        return ((a2[0] | b2[0]) & (a2[1] | b2[1])) | c2[1];
    endfunction

    function automatic logic lane_e(input logic [1:0] a2, input logic [1:0] b2,
                                    input logic [1:0] c2);
        return ((a2[1] | b2[0]) & (a2[0] | b2[1])) | c2[0];
    endfunction

    // All-ones value of a counter of the given width (clamped at 64 bits).
    function automatic longint unsigned cnt_sat_value(input int unsigned width);
        return (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/lane_logic_pipe_stage.sv
// One elastic register stage: a valid bit plus the packed {e, d} lane bits,
// captured whenever the stage's load enable is high.
module lane_logic_pipe_stage #(
    parameter int NUM_LANES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   in_valid,
    input  logic [2*NUM_LANES-1:0] in_data,
    output logic                   valid,
    output logic [2*NUM_LANES-1:0] data
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= in_valid;
            data  <= in_data;
        end
    end

endmodule

// File: rtl/lane_logic_array.sv
// NUM_LANES registered d/e logic cells behind an elastic valid/ready pipeline,
// with optional sticky OR-accumulation and per-lane saturating d event counters.
module lane_logic_array
    import lane_logic_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int PIPE_DEPTH = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_LANES*LANE_A_WIDTH-1:0] a,
    input  logic [NUM_LANES*2-1:0]            b,
    input  logic [NUM_LANES*2-1:0]            c,
    input  logic                              sticky,
    input  logic                              clear,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_LANES-1:0]              d,
    output logic [NUM_LANES-1:0]              e,
    output logic [NUM_LANES*CNT_WIDTH-1:0]    d_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_sat_value(CNT_WIDTH));

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value,
                                                     input logic inc);
        return (inc && (value != CNT_MAX)) ? value + 1'b1 : value;
    endfunction

    logic                   accept;
    logic [NUM_LANES-1:0]   dn, en, ds, es;
    logic [NUM_LANES-1:0]   acc_d, acc_e, acc_d_eff, acc_e_eff;
    logic [CNT_WIDTH-1:0]   cnt [NUM_LANES];
    logic [PIPE_DEPTH-1:0]  vld, load;
    logic [2*NUM_LANES-1:0] data_p [PIPE_DEPTH];
    logic                   unused_a_bits;

    // Only bits 0 and 1 of each lane's a byte are functional.
    assign unused_a_bits = ^a;

    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            dn[k] = lane_d(a[k*LANE_A_WIDTH +: 2], b[2*k +: 2], c[2*k +: 2]);
            en[k] = lane_e(a[k*LANE_A_WIDTH +: 2], b[2*k +: 2], c[2*k +: 2]);
        end
    end

    // A clear on the accepting cycle hides the old accumulator from this sample.
    assign acc_d_eff = clear ? '0 : acc_d;
    assign acc_e_eff = clear ? '0 : acc_e;
    assign ds        = sticky ? (dn | acc_d_eff) : dn;
    assign es        = sticky ? (en | acc_e_eff) : en;

    // Backward ready chain: a stage may load if it is empty or its successor loads.
    always_comb begin
        logic nxt;
        nxt  = out_ready;
        load = '0;
        for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
            nxt     = ~vld[i] | nxt;
            load[i] = nxt;
        end
    end

    assign in_ready = load[0];
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_d <= '0;
            acc_e <= '0;
            for (int k = 0; k < NUM_LANES; k++) cnt[k] <= '0;
        end else if (accept) begin
            acc_d <= sticky ? ds : '0;
            acc_e <= sticky ? es : '0;
            for (int k = 0; k < NUM_LANES; k++)
                cnt[k] <= sat_inc(clear ? '0 : cnt[k], dn[k]);
        end else if (clear) begin
            acc_d <= '0;
            acc_e <= '0;
            for (int k = 0; k < NUM_LANES; k++) cnt[k] <= '0;
        end
    end

    // Stage 0 captures the sticky-processed sample; later stages shift it along.
    for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stage
        logic                   stage_in_valid;
        logic [2*NUM_LANES-1:0] stage_in_data;
        if (i == 0) begin : g_head
            assign stage_in_valid = in_valid;
            assign stage_in_data  = {es, ds};
        end else begin : g_body
            assign stage_in_valid = vld[i-1];
            assign stage_in_data  = data_p[i-1];
        end
        lane_logic_pipe_stage #(.NUM_LANES(NUM_LANES)) u_stage (
            .clock    (clock),
            .reset    (reset),
            .load     (load[i]),
            .in_valid (stage_in_valid),
            .in_data  (stage_in_data),
            .valid    (vld[i]),
            .data     (data_p[i])
        );
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_cnt
        assign d_count[k*CNT_WIDTH +: CNT_WIDTH] = cnt[k];
    end

    assign out_valid = vld[PIPE_DEPTH-1];
    assign d         = data_p[PIPE_DEPTH-1][NUM_LANES-1:0];
    assign e         = data_p[PIPE_DEPTH-1][2*NUM_LANES-1:NUM_LANES];

endmodule
